// File: rtl/cpu4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu4_pkg
// Description : Shared ISA constants and fetch FSM state encoding for the
//               4-bit CPU. FS_HALT exists only with IFETCH_HALT_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu4_pkg;

    localparam int INS_W  = 11;
    localparam int ADDR_W = 4;

    localparam int OPC_HI = 10;
    localparam int OPC_LO = 8;

    localparam logic [2:0]  OPC_HALT     = 3'b111;
    localparam logic [10:0] INS_SET_PC_0 = 11'b01100000000;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_LOAD  = 3'd1,
        FS_START = 3'd2,
        FS_RUN   = 3'd3
`ifdef IFETCH_HALT_DETECT_EN
        ,
        FS_HALT  = 3'd4
`endif
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_if
// Description : Program-load, control and fetch-output bundle of ifetch.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifetch_if #(
    parameter int INS_W  = cpu4_pkg::INS_W,
    parameter int ADDR_W = cpu4_pkg::ADDR_W
);
    logic              load_req;
    logic              prog_valid;
    logic              prog_ready;
    logic [ADDR_W-1:0] prog_addr;
    logic [INS_W-1:0]  prog_data;
    logic              prog_last;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] pc_curr;
    logic [INS_W-1:0]  ins;
    logic              ins_valid;
    logic              set_pc;
    logic              halted;

    modport master (
        output load_req, prog_valid, prog_addr, prog_data, prog_last,
               start, stop, pc_curr,
        input  prog_ready, ins, ins_valid, set_pc, halted
    );

    modport slave (
        input  load_req, prog_valid, prog_addr, prog_data, prog_last,
               start, stop, pc_curr,
        output prog_ready, ins, ins_valid, set_pc, halted
    );
endinterface
`default_nettype wire

// File: rtl/ifetch_mem.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_mem
// Description : Instruction register file, synchronous write, asynchronous
//               read, contents intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_mem #(
    parameter int INS_W  = 11,
    parameter int ADDR_W = 4
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [INS_W-1:0]  i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [INS_W-1:0]  o_rdata
);
    logic [INS_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch
// Description : Instruction fetch stage: program load, PC-init issue and
//               registered fetch. Option macro: IFETCH_HALT_DETECT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch #(
    parameter int INS_W  = cpu4_pkg::INS_W,
    parameter int ADDR_W = cpu4_pkg::ADDR_W
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ifetch_if.slave   bus
);
    import cpu4_pkg::*;

    fetch_state_t     r_state;
    logic [INS_W-1:0] r_ins;
    logic             r_ins_valid;
    logic             r_set_pc;
    logic             r_prog_ready;
    logic [INS_W-1:0] w_rd_data;
    logic             w_prog_we;

    // prog_ready is high exactly while in LOAD; a handshake in a reset cycle is dropped.
    assign w_prog_we = rst_n && r_prog_ready && bus.prog_valid;

    ifetch_mem #(
        .INS_W  (INS_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_prog_we),
        .i_waddr (bus.prog_addr),
        .i_wdata (bus.prog_data),
        .i_raddr (bus.pc_curr),
        .o_rdata (w_rd_data)
    );

`ifdef IFETCH_HALT_DETECT_EN
    logic r_halted;
    assign bus.halted = r_halted;
`else
    assign bus.halted = 1'b0;
`endif

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FS_IDLE;
            r_ins        <= '0;
            r_ins_valid  <= 1'b0;
            r_set_pc     <= 1'b0;
            r_prog_ready <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
            r_halted     <= 1'b0;
`endif
        end else begin
            case (r_state)
                FS_IDLE: begin
                    r_ins_valid <= 1'b0;
                    r_set_pc    <= 1'b0;
                    if (bus.load_req) begin
                        r_state      <= FS_LOAD;
                        r_prog_ready <= 1'b1;
                    end else if (bus.start) begin
                        r_state     <= FS_START;
                        r_ins       <= INS_SET_PC_0;
                        r_set_pc    <= 1'b1;
                        r_ins_valid <= 1'b1;
                    end
                end
                FS_LOAD: begin
                    r_ins_valid <= 1'b0;
                    r_set_pc    <= 1'b0;
                    if (bus.prog_valid && bus.prog_last) begin
                        r_state      <= FS_IDLE;
                        r_prog_ready <= 1'b0;
                    end
                end
                FS_START: begin
                    r_state     <= FS_RUN;
                    r_ins       <= w_rd_data;
                    r_ins_valid <= 1'b1;
                    r_set_pc    <= 1'b0;
                end
                FS_RUN: begin
                    r_set_pc <= 1'b0;
                    if (bus.stop) begin
                        r_state     <= FS_IDLE;
                        r_ins_valid <= 1'b0;
`ifdef IFETCH_HALT_DETECT_EN
                    end else if (r_ins[OPC_HI:OPC_LO] == OPC_HALT) begin
                        // The halt word has had its single valid cycle.
                        r_state     <= FS_HALT;
                        r_ins_valid <= 1'b0;
                        r_halted    <= 1'b1;
`endif
                    end else begin
                        r_ins       <= w_rd_data;
                        r_ins_valid <= 1'b1;
                    end
                end
`ifdef IFETCH_HALT_DETECT_EN
                FS_HALT: begin
                    r_ins_valid <= 1'b0;
                    r_set_pc    <= 1'b0;
                    if (bus.load_req) begin
                        r_state      <= FS_LOAD;
                        r_prog_ready <= 1'b1;
                        r_halted     <= 1'b0;
                    end else if (bus.start) begin
                        r_state     <= FS_START;
                        r_ins       <= INS_SET_PC_0;
                        r_set_pc    <= 1'b1;
                        r_ins_valid <= 1'b1;
                        r_halted    <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state      <= FS_IDLE;
                    r_ins_valid  <= 1'b0;
                    r_set_pc     <= 1'b0;
                    r_prog_ready <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ins        = r_ins;
    assign bus.ins_valid  = r_ins_valid;
    assign bus.set_pc     = r_set_pc;
    assign bus.prog_ready = r_prog_ready;
endmodule
`default_nettype wire

// File: tb/tb_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch
// Description : Self-checking bench for ifetch (vector tables, hand-written
//               corner sequences, randomized load/run against a memory model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch;
    localparam int INS_W  = 11;
    localparam int ADDR_W = 4;
    localparam logic [10:0] SETPC = 11'b01100000000;
    localparam logic [10:0] HALTW = 11'b11100000000;

    typedef struct {
        logic [3:0]  addr;
        logic [10:0] data;
        logic        last;
    } wr_vec_t;

    typedef struct {
        logic [3:0]  pc;
        logic [10:0] exp_ins;
    } run_vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_if #(.INS_W(INS_W), .ADDR_W(ADDR_W)) bus ();

    ifetch #(.INS_W(INS_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [10:0] model_mem [16];
    bit          known     [16];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic enter_load;
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [10:0] d, input logic last);
        bus.prog_valid = 1'b1;
        bus.prog_addr  = a;
        bus.prog_data  = d;
        bus.prog_last  = last;
        tick();
        bus.prog_valid = 1'b0;
        bus.prog_last  = 1'b0;
        model_mem[a] = d;
        known[a]     = 1'b1;
    endtask

    task automatic start_run;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_set_pc", 32'(bus.set_pc), 32'd1);
        check("start_ins", 32'(bus.ins), 32'(SETPC));
    endtask

    task automatic fetch(input logic [3:0] pc, input logic [10:0] exp, input string name);
        bus.pc_curr = pc;
        tick();
        check(name, 32'(bus.ins), 32'(exp));
        check({name, "_valid"}, 32'(bus.ins_valid), 32'd1);
    endtask

    task automatic stop_run;
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_valid", 32'(bus.ins_valid), 32'd0);
    endtask

    wr_vec_t  wr_tab  [4];
    run_vec_t run_tab [5];

    initial begin
        wr_tab[0] = '{4'd0, 11'h001, 1'b0};
        wr_tab[1] = '{4'd1, 11'h002, 1'b0};
        wr_tab[2] = '{4'd2, 11'h003, 1'b0};
        wr_tab[3] = '{4'd3, 11'h004, 1'b1};
        run_tab[0] = '{4'd0, 11'h001};
        run_tab[1] = '{4'd1, 11'h002};
        run_tab[2] = '{4'd2, 11'h003};
        run_tab[3] = '{4'd3, 11'h004};
        run_tab[4] = '{4'd2, 11'h003};
        for (int i = 0; i < 16; i++) known[i] = 1'b0;

        bus.load_req   = 1'b0;
        bus.prog_valid = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_data  = '0;
        bus.prog_last  = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.pc_curr    = '0;

        // Reset and idle
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_ins", 32'(bus.ins), 32'd0);
        check("rst_valid", 32'(bus.ins_valid), 32'd0);
        check("rst_set_pc", 32'(bus.set_pc), 32'd0);
        check("rst_ready", 32'(bus.prog_ready), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_ready", 32'(bus.prog_ready), 32'd0);
        check("idle_valid", 32'(bus.ins_valid), 32'd0);

        // Load, with start/stop ignored while loading
        enter_load();
        check("load_ready", 32'(bus.prog_ready), 32'd1);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check("load_ignores_ctl", 32'(bus.prog_ready), 32'd1);
        check("load_no_set_pc", 32'(bus.set_pc), 32'd0);
        for (int i = 0; i < 4; i++) begin
            write_word(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].last);
            check("load_ready_seq", 32'(bus.prog_ready), 32'(!wr_tab[i].last));
        end

        // A program word outside LOAD must not be written
        bus.prog_valid = 1'b1;
        bus.prog_addr  = 4'd2;
        bus.prog_data  = 11'h7FF;
        tick();
        bus.prog_valid = 1'b0;

        start_run();
        check("start_valid", 32'(bus.ins_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            fetch(run_tab[i].pc, run_tab[i].exp_ins, "run_vec");
            check("run_set_pc", 32'(bus.set_pc), 32'd0);
        end
        stop_run();
        check("stop_ins_hold", 32'(bus.ins), 32'h003);
        tick();
        check("idle_after_stop", 32'(bus.ins_valid), 32'd0);

        // load_req beats start in IDLE
        bus.load_req = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.load_req = 1'b0;
        bus.start    = 1'b0;
        check("prio_ready", 32'(bus.prog_ready), 32'd1);
        check("prio_set_pc", 32'(bus.set_pc), 32'd0);
        write_word(4'd4, 11'h0AA, 1'b0);
        write_word(4'd5, HALTW, 1'b1);

        // Halt word handling
        start_run();
        fetch(4'd4, 11'h0AA, "pre_halt");
        fetch(4'd5, HALTW, "halt_word");
        bus.pc_curr = 4'd0;
        tick();
`ifdef IFETCH_HALT_DETECT_EN
        check("halt_valid", 32'(bus.ins_valid), 32'd0);
        check("halt_flag", 32'(bus.halted), 32'd1);
        check("halt_ins_hold", 32'(bus.ins), 32'(HALTW));
        tick();
        check("halt_stays", 32'(bus.halted), 32'd1);
        start_run();
        check("halt_cleared", 32'(bus.halted), 32'd0);
        fetch(4'd0, 11'h001, "after_halt");
`else
        check("nohalt_stream", 32'(bus.ins), 32'h001);
        check("nohalt_valid", 32'(bus.ins_valid), 32'd1);
        check("nohalt_flag", 32'(bus.halted), 32'd0);
`endif
        // stop wins over a halt fetch in the same cycle
        fetch(4'd5, HALTW, "halt_word2");
        stop_run();
        check("stop_vs_halt", 32'(bus.halted), 32'd0);
        tick();
        check("stop_vs_halt_idle", 32'(bus.halted), 32'd0);

        // Randomized load/run rounds against the memory model
        for (int r = 0; r < 4; r++) begin
            int n;
            enter_load();
            n = (r == 0) ? 16 : int'($urandom_range(3, 10));
            for (int i = 0; i < n; i++) begin
                logic [3:0] a;
                a = (r == 0) ? 4'(i) : 4'($urandom_range(0, 15));
                if ($urandom_range(0, 3) == 0) begin
                    bus.prog_addr = a;
                    bus.prog_data = 11'h7FF;
                    tick();
                end
                write_word(a, 11'($urandom_range(0, 11'h6FF)), (i == n - 1) ? 1'b1 : 1'b0);
            end
            check("rnd_ready_drop", 32'(bus.prog_ready), 32'd0);
            bus.prog_valid = 1'b1;
            bus.prog_addr  = 4'($urandom_range(0, 15));
            bus.prog_data  = 11'h7FF;
            tick();
            bus.prog_valid = 1'b0;
            start_run();
            for (int k = 0; k < 20; k++) begin
                logic [3:0] p;
                p = 4'($urandom_range(0, 15));
                fetch(p, model_mem[p], "rnd_fetch");
            end
            stop_run();
        end

        // Reset during LOAD keeps earlier words and drops the in-flight one
        enter_load();
        write_word(4'd1, 11'h07F, 1'b0);
        bus.prog_valid = 1'b1;
        bus.prog_addr  = 4'd1;
        bus.prog_data  = 11'h123;
        rst_n = 1'b0;
        tick();
        bus.prog_valid = 1'b0;
        rst_n = 1'b1;
        check("midload_rst_ready", 32'(bus.prog_ready), 32'd0);
        check("midload_rst_ins", 32'(bus.ins), 32'd0);
        tick();
        check("midload_idle", 32'(bus.prog_ready), 32'd0);
        start_run();
        fetch(4'd1, 11'h07F, "midload_keep");
        stop_run();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the 4-bit CPU, sitting directly upstream of the program counter. It holds a 16-word × 11-bit instruction memory, loaded through a ready/valid program port. On run it issues the PC-initialise instruction, then returns one registered instruction per cycle from the address on `pc_curr`. Its `ins` and `set_pc` outputs drive the PC's `INS` and `set_pc` inputs. `pc_curr` is fed back from the PC's `PC_CURR`.

## Interface
- `INS_W`, default 11: instruction width.
- `ADDR_W`, default 4: address width; memory depth is 2**ADDR_W.
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `load_req`, in, 1: request entry into program-load mode.
- `prog_valid`, in, 1: program word present.
- `prog_ready`, out, 1: block accepts program words.
- `prog_addr`, in, ADDR_W: write address.
- `prog_data`, in, INS_W: instruction word.
- `prog_last`, in, 1: qualifies the final word of a load.
- `start`, in, 1: begin execution.
- `stop`, in, 1: abort execution and return to idle.
- `pc_curr`, in, ADDR_W: current PC from the program counter.
- `ins`, out, INS_W: registered instruction to the PC and decoder.
- `ins_valid`, out, 1: `ins` is a live instruction.
- `set_pc`, out, 1: PC load strobe.
- `halted`, out, 1: the halt instruction has been fetched.

## Operation
- FSM states:
  - IDLE: reset state. `load_req` → LOAD. Otherwise `start` → START. If both are asserted, `load_req` wins.
  - LOAD: `prog_ready`=1. On `prog_valid`&&`prog_ready`, write `prog_data` to `mem[prog_addr]`. If that handshake has `prog_last`=1, the word is written and the state goes to IDLE. `start` and `stop` are ignored in LOAD.
  - START: lasts one cycle.
    - Registers `ins`←`INS_SET_PC_0` (11'b01100000000), `set_pc`←1, `ins_valid`←1.
    - Always goes to RUN.
  - RUN: every cycle registers `ins`←`mem[pc_curr]`, `ins_valid`←1, `set_pc`←0. `stop` → IDLE.
  - HALT: only exists when the configuration macro is defined. `ins` holds its value, `ins_valid`=0, `halted`=1. `load_req` → LOAD, else `start` → START.
- On entering IDLE or LOAD: `ins_valid`←0 and `set_pc`←0; `ins` holds its last value.
- `prog_valid` outside LOAD is ignored; no write occurs.
- Writes to the same address overwrite. Addresses wrap naturally at ADDR_W bits.
- The PC computes its next value from registered `ins`. Branches therefore have one delay slot: the word at the PC value following the branch's fetch address is still issued.
- Reset:
  - Clears the FSM to IDLE, `ins`=0, `ins_valid`=0, `set_pc`=0, `prog_ready`=0, `halted`=0.
  - Memory contents are not reset. Reset mid-LOAD keeps words already written; an in-flight handshake in the reset cycle is dropped.
- Memory contents before the first load are undefined; software must load before `start`.

## Timing
- Program write: the word is visible to a RUN-state fetch from the cycle after the accepting edge.
- Fetch latency is 1 cycle: `ins` after edge k equals `mem[pc_curr]` sampled at edge k.
- `prog_ready` is a registered state decode, high from the first cycle in LOAD. A handshake with `prog_last` drops it on the next cycle.
- `start` in IDLE: `set_pc`/`ins_valid` rise 1 cycle later (START), and the first memory fetch appears 2 cycles later.
- `stop` in RUN: `ins_valid` falls at the next edge.
- If `stop` and a halt fetch occur in the same cycle, `stop` wins: go to IDLE with `halted`=0.

## Configuration
- `IFETCH_HALT_DETECT_EN` defined:
  - In RUN, a fetched word with `ins[10:8]`==`OPC_HALT` (3'b111) is presented once with `ins_valid`=1.
  - The FSM then enters HALT: the next cycle has `ins_valid`=0 and `halted`=1.
  - `halted` clears on leaving HALT.
- Undefined: opcode 3'b111 passes through as an ordinary word, the HALT state does not exist, and `halted` is tied 0.

## Structure
- Shared package `cpu4_pkg` holds:
  - ISA constants: `INS_W`, `ADDR_W`, `OPC_HALT`, `INS_SET_PC_0`.
  - The fetch FSM state enum.
  - The opcode field bounds.
- One sub-module, `ifetch_mem`: 2**ADDR_W × INS_W register file with a synchronous write port, an asynchronous read port, and no reset.
- `ifetch` contains the FSM and the `ins`/`set_pc`/`ins_valid` output registers.

## Test plan
- Reset then idle: hold `rst_n`=0 for 2 cycles → `ins`=0, `ins_valid`=0, `set_pc`=0, `prog_ready`=0, `halted`=0. With no request, the FSM stays in IDLE.
- Load: `load_req` → `prog_ready`=1. Write `mem[0..3]`=11'h001..11'h004, with `prog_last` on address 3 → `prog_ready`=0 next cycle. Words written with `prog_valid` outside LOAD are ignored; readback confirms `mem[2]` unchanged.
- Run sequence: `start` → next cycle `ins`=11'b01100000000 with `set_pc`=1. Then drive `pc_curr`=0,1,2 → `ins`=11'h001,11'h002,11'h003, one cycle after each.
- Priority: assert `load_req`&&`start` in IDLE → enter LOAD.
- Stop: `stop` in RUN → IDLE and `ins_valid`=0 next cycle. `stop` in LOAD is ignored.
- Halt (with `IFETCH_HALT_DETECT_EN`): `mem[5]`=11'b11100000000 and `pc_curr`=5 → that word is issued with `ins_valid`=1. Next cycle `halted`=1 and `ins_valid`=0. Then `start` → START, with `halted`=0. With the macro undefined, the same word streams with `halted`=0.
- Reset mid-load: after writing `mem[1]`=11'h07F, pulse `rst_n`=0 → FSM returns to IDLE and `mem[1]` still reads 11'h07F on the next run.
